// File: rtl/chunked_extender_pkg.sv
// -----------------------------------------------------------------------------
// chunked_extender_pkg
// Shared definitions for the chunked operand extender:
//   ext_mode_e : fill-mode encodings presented on in_mode
//   state_e    : control FSM states of the top level
//   fill_bit() : selects the bit replicated above the operand for a given mode
// -----------------------------------------------------------------------------
package chunked_extender_pkg;

    typedef enum logic [1:0] {
        EXT_ZERO = 2'b00,
        EXT_SIGN = 2'b01,
        EXT_ONES = 2'b10,
        EXT_RSVD = 2'b11
    } ext_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_FILL = 2'b01,
        ST_HOLD = 2'b10
    } state_e;

    // Reserved mode behaves like zero-extend; the transaction is flagged instead.
    function automatic logic fill_bit(input ext_mode_e mode, input logic msb);
        case (mode)
            EXT_SIGN: return msb;
            EXT_ONES: return 1'b1;
            default:  return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/ext_chunk_gen.sv
// -----------------------------------------------------------------------------
// ext_chunk_gen
// Combinational generator of one CHUNK_W-bit slice of the extended result.
// Result bit (idx*CHUNK_W + k) takes in_data at that position when it lies
// inside the operand, otherwise the fill bit, so a slice straddling the
// operand boundary mixes both sources.
// Ports:
//   in_data [IN_W]    latched operand
//   fill    [1]       bit replicated above the operand
//   idx     [IDX_W]   slice index being produced
//   chunk   [CHUNK_W] generated slice
// -----------------------------------------------------------------------------
module ext_chunk_gen
    import chunked_extender_pkg::*;
#(
    parameter int IN_W    = 4,
    parameter int CHUNK_W = 4,
    parameter int IDX_W   = 3
) (
    input  logic [IN_W-1:0]    in_data,
    input  logic               fill,
    input  logic [IDX_W-1:0]   idx,
    output logic [CHUNK_W-1:0] chunk
);

    // Constant-indexed mux per bit avoids a variable select that could run
    // past the operand.
    always_comb begin
        chunk = {CHUNK_W{fill}};
        for (int k = 0; k < CHUNK_W; k++) begin
            for (int j = 0; j < IN_W; j++) begin
                if (int'(idx) * CHUNK_W + k == j) begin
                    chunk[k] = in_data[j];
                end
            end
        end
    end

endmodule

// File: rtl/chunked_extender.sv
// -----------------------------------------------------------------------------
// chunked_extender
// Multi-cycle zero/sign/ones extender. An IN_W-bit operand accepted on the
// input handshake is expanded into an OUT_W-bit result, one CHUNK_W slice per
// clock, then held on the output handshake until consumed.
// Ports:
//   clk, rst_n            clock (rising edge), synchronous active-low reset
//   in_valid / in_ready   operand handshake
//   in_data  [IN_W]       operand
//   in_mode  [2]          00 zero, 01 sign, 10 ones, 11 reserved (flagged)
//   out_valid / out_ready result handshake
//   out_data [OUT_W]      extended result
//   out_err  [1]          result came from a reserved-mode transaction
//   busy     [1]          FSM is not idle
// -----------------------------------------------------------------------------
module chunked_extender
    import chunked_extender_pkg::*;
#(
    parameter int IN_W    = 4,
    parameter int OUT_W   = 32,
    parameter int CHUNK_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_err,
    output logic             busy
);

    localparam int NCHUNK = OUT_W / CHUNK_W;
    localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

    if (CHUNK_W < 1 || IN_W < 1 || IN_W > OUT_W || (OUT_W % CHUNK_W) != 0) begin : g_param_check
        $error("chunked_extender: illegal parameters IN_W=%0d OUT_W=%0d CHUNK_W=%0d",
               IN_W, OUT_W, CHUNK_W);
    end

    state_e             state_q, state_d;
    logic [IN_W-1:0]    data_q, data_d;
    logic               fill_q, fill_d;
    logic               err_q, err_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [OUT_W-1:0]   out_data_q, out_data_d;
    logic [CHUNK_W-1:0] chunk;
    logic               accept;

    ext_chunk_gen #(
        .IN_W    (IN_W),
        .CHUNK_W (CHUNK_W),
        .IDX_W   (IDX_W)
    ) u_chunk_gen (
        .in_data (data_q),
        .fill    (fill_q),
        .idx     (idx_q),
        .chunk   (chunk)
    );

    // HOLD passes out_ready through so a consumed result and a new operand can
    // share one edge; reset forces the input closed.
    assign in_ready  = rst_n && ((state_q == ST_IDLE) || (state_q == ST_HOLD && out_ready));
    assign accept    = in_valid && in_ready;
    assign out_valid = (state_q == ST_HOLD);
    assign out_err   = out_valid && err_q;
    assign out_data  = out_data_q;
    assign busy      = (state_q != ST_IDLE);

    always_comb begin
        // NOTE: every signal gets its hold value first so no path through the
        // case below leaves one unassigned (which would infer a latch).
        state_d    = state_q;
        data_d     = data_q;
        fill_d     = fill_q;
        err_d      = err_q;
        idx_d      = idx_q;
        out_data_d = out_data_q;

        case (state_q)
            ST_FILL: begin
                for (int c = 0; c < NCHUNK; c++) begin
                    if (idx_q == IDX_W'(c)) begin
                        out_data_d[c*CHUNK_W +: CHUNK_W] = chunk;
                    end
                end
                if (idx_q == LAST_IDX) begin
                    state_d = ST_HOLD;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            ST_HOLD: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: ;
            default: state_d = ST_IDLE;
        endcase

        // accept is only possible in IDLE or in HOLD while the result drains,
        // so it overrides whatever the case chose.
        if (accept) begin
            data_d     = in_data;
            fill_d     = fill_bit(ext_mode_e'(in_mode), in_data[IN_W-1]);
            err_d      = (ext_mode_e'(in_mode) == EXT_RSVD);
            out_data_d = '0;
            idx_d      = '0;
            state_d    = ST_FILL;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            data_q     <= '0;
            fill_q     <= 1'b0;
            err_q      <= 1'b0;
            idx_q      <= '0;
            out_data_q <= '0;
        end else begin
            state_q    <= state_d;
            data_q     <= data_d;
            fill_q     <= fill_d;
            err_q      <= err_d;
            idx_q      <= idx_d;
            out_data_q <= out_data_d;
        end
    end

endmodule

// File: tb/tb_chunked_extender.sv
// -----------------------------------------------------------------------------
// tb_chunked_extender
// Two instances: defaults (4 -> 32, nibble slices) and 12 -> 16 with byte
// slices. Accepted operands push the reference result into a queue; output
// monitors pop and compare on every output handshake and check latency when
// out_valid first rises.
// -----------------------------------------------------------------------------
module tb_chunked_extender;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic        in_valid_a, in_ready_a, out_valid_a, out_ready_a, out_err_a, busy_a;
    logic [3:0]  in_data_a;
    logic [1:0]  in_mode_a;
    logic [31:0] out_data_a;

    logic        in_valid_b, in_ready_b, out_valid_b, out_ready_b, out_err_b, busy_b;
    logic [11:0] in_data_b;
    logic [1:0]  in_mode_b;
    logic [15:0] out_data_b;

    chunked_extender u_dut_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid_a),
        .in_ready  (in_ready_a),
        .in_data   (in_data_a),
        .in_mode   (in_mode_a),
        .out_valid (out_valid_a),
        .out_ready (out_ready_a),
        .out_data  (out_data_a),
        .out_err   (out_err_a),
        .busy      (busy_a)
    );

    chunked_extender #(.IN_W(12), .OUT_W(16), .CHUNK_W(8)) u_dut_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid_b),
        .in_ready  (in_ready_b),
        .in_data   (in_data_b),
        .in_mode   (in_mode_b),
        .out_valid (out_valid_b),
        .out_ready (out_ready_b),
        .out_data  (out_data_b),
        .out_err   (out_err_b),
        .busy      (busy_b)
    );

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          acc;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    bit   rand_bp = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference: mask operand, then OR in the upper bits when the fill is 1.
    function automatic logic [31:0] model(input logic [31:0] d, input logic [1:0] m,
                                          input int in_w, input int out_w);
        logic [31:0] in_mask, out_mask, v;
        in_mask  = (32'd1 << in_w) - 32'd1;
        out_mask = (out_w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << out_w) - 32'd1);
        v = d & in_mask;
        case (m)
            2'b01: if (((v >> (in_w - 1)) & 32'd1) != 0) v = v | (out_mask & ~in_mask);
            2'b10: v = v | (out_mask & ~in_mask);
            default: ;
        endcase
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s", name);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Accept monitors: sample the handshake at the edge it takes effect.
    initial forever begin
        @(posedge clk);
        if (rst_n && in_valid_a && in_ready_a)
            q_a.push_back('{model({28'b0, in_data_a}, in_mode_a, 4, 32), in_mode_a == 2'b11, cyc + 1});
        if (rst_n && in_valid_b && in_ready_b)
            q_b.push_back('{model({20'b0, in_data_b}, in_mode_b, 12, 16), in_mode_b == 2'b11, cyc + 1});
    end

    // Output monitor, instance A.
    initial begin
        bit   seen = 0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                seen = 0;
            end else if (out_valid_a) begin
                if (!seen) begin
                    seen = 1;
                    if (q_a.size() == 0) fail("unexpected_out_a");
                    else check("latency_a", 32'(cyc - q_a[0].acc), 32'd8);
                end
                if (out_ready_a) begin
                    seen = 0;
                    if (q_a.size() > 0) begin
                        e = q_a.pop_front();
                        check("data_a", out_data_a, e.data);
                        check("err_a", {31'b0, out_err_a}, {31'b0, e.err});
                    end
                end
            end
        end
    end

    // Output monitor, instance B.
    initial begin
        bit   seen = 0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                seen = 0;
            end else if (out_valid_b) begin
                if (!seen) begin
                    seen = 1;
                    if (q_b.size() == 0) fail("unexpected_out_b");
                    else check("latency_b", 32'(cyc - q_b[0].acc), 32'd2);
                end
                if (out_ready_b) begin
                    seen = 0;
                    if (q_b.size() > 0) begin
                        e = q_b.pop_front();
                        check("data_b", {16'b0, out_data_b}, e.data);
                        check("err_b", {31'b0, out_err_b}, {31'b0, e.err});
                    end
                end
            end
        end
    end

    // Random backpressure on instance A.
    initial forever begin
        @(posedge clk);
        #1;
        if (rand_bp) out_ready_a = 1'($urandom_range(0, 1));
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // Called just after an edge; holds in_valid until the handshake edge, then
    // scrambles data/mode to prove they are sampled only at accept.
    task automatic send_a(input logic [3:0] d, input logic [1:0] m);
        bit ok = 0;
        in_valid_a = 1'b1;
        in_data_a  = d;
        in_mode_a  = m;
        for (int n = 0; n < 200; n++) begin
            @(posedge clk);
            if (in_ready_a) begin
                ok = 1;
                break;
            end
        end
        #1;
        in_valid_a = 1'b0;
        in_data_a  = 4'($urandom);
        in_mode_a  = 2'($urandom);
        if (!ok) fail("accept_timeout_a");
    endtask

    task automatic send_b(input logic [11:0] d, input logic [1:0] m);
        bit ok = 0;
        in_valid_b = 1'b1;
        in_data_b  = d;
        in_mode_b  = m;
        for (int n = 0; n < 200; n++) begin
            @(posedge clk);
            if (in_ready_b) begin
                ok = 1;
                break;
            end
        end
        #1;
        in_valid_b = 1'b0;
        in_data_b  = 12'($urandom);
        in_mode_b  = 2'($urandom);
        if (!ok) fail("accept_timeout_b");
    endtask

    task automatic drain_a;
        int n = 0;
        while ((q_a.size() != 0 || out_valid_a) && n < 400) begin
            tick();
            n++;
        end
        check("drain_a", 32'(q_a.size()), 32'd0);
    endtask

    task automatic drain_b;
        int n = 0;
        while ((q_b.size() != 0 || out_valid_b) && n < 400) begin
            tick();
            n++;
        end
        check("drain_b", 32'(q_b.size()), 32'd0);
    endtask

    initial begin
        rst_n       = 1'b0;
        in_valid_a  = 1'b0; in_data_a = '0; in_mode_a = '0; out_ready_a = 1'b1;
        in_valid_b  = 1'b0; in_data_b = '0; in_mode_b = '0; out_ready_b = 1'b1;

        // Reset state.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready_a", {31'b0, in_ready_a}, 32'd0);
        check("rst_out_valid_a", {31'b0, out_valid_a}, 32'd0);
        check("rst_out_data_a", out_data_a, 32'd0);
        check("rst_out_err_a", {31'b0, out_err_a}, 32'd0);
        check("rst_busy_a", {31'b0, busy_a}, 32'd0);
        check("rst_in_ready_b", {31'b0, in_ready_b}, 32'd0);
        check("rst_busy_b", {31'b0, busy_b}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        check("post_rst_in_ready_a", {31'b0, in_ready_a}, 32'd1);
        tick();

        // Directed modes, back-to-back with out_ready held high.
        send_a(4'hA, 2'b00);
        send_a(4'hA, 2'b01);
        send_a(4'h5, 2'b01);
        send_a(4'h3, 2'b10);
        send_a(4'hA, 2'b11);
        drain_a();

        // Input activity during FILL is ignored.
        send_a(4'h9, 2'b01);
        for (int i = 0; i < 5; i++) begin
            in_valid_a = 1'b1;
            in_data_a  = 4'($urandom);
            in_mode_a  = 2'($urandom);
            check("fill_in_ready_a", {31'b0, in_ready_a}, 32'd0);
            tick();
        end
        in_valid_a = 1'b0;
        drain_a();

        // Backpressure in HOLD, then release with a simultaneous new operand.
        out_ready_a = 1'b0;
        send_a(4'hC, 2'b01);
        for (int n = 0; n < 50 && !out_valid_a; n++) tick();
        check("bp_valid_seen", {31'b0, out_valid_a}, 32'd1);
        for (int i = 0; i < 5; i++) begin
            check("bp_hold_valid", {31'b0, out_valid_a}, 32'd1);
            check("bp_hold_data", out_data_a, 32'hFFFF_FFFC);
            check("bp_hold_in_ready", {31'b0, in_ready_a}, 32'd0);
            tick();
        end
        out_ready_a = 1'b1;
        send_a(4'h7, 2'b00);
        check("b2b_out_valid_low", {31'b0, out_valid_a}, 32'd0);
        check("b2b_busy", {31'b0, busy_a}, 32'd1);
        drain_a();

        // Reset while FILL is at idx=3 aborts the operand.
        send_a(4'hF, 2'b10);
        repeat (3) tick();
        rst_n = 1'b0;
        @(negedge clk);
        check("mid_rst_in_ready", {31'b0, in_ready_a}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        q_a.delete();
        #1;
        check("abort_in_ready", {31'b0, in_ready_a}, 32'd1);
        check("abort_out_valid", {31'b0, out_valid_a}, 32'd0);
        check("abort_out_data", out_data_a, 32'd0);
        check("abort_busy", {31'b0, busy_a}, 32'd0);
        repeat (12) tick();
        send_a(4'h6, 2'b01);
        drain_a();

        // Random operands and modes under random backpressure.
        rand_bp = 1;
        for (int i = 0; i < 30; i++) begin
            send_a(4'($urandom), 2'($urandom));
            repeat ($urandom_range(0, 2)) tick();
        end
        rand_bp = 0;
        out_ready_a = 1'b1;
        drain_a();

        // Straddling-chunk configuration.
        send_b(12'h800, 2'b01);
        send_b(12'h7FF, 2'b01);
        drain_b();
        for (int i = 0; i < 20; i++) begin
            send_b(12'($urandom), 2'($urandom));
            repeat ($urandom_range(0, 1)) tick();
        end
        drain_b();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
